// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM stage bus: EX-side handshake/payload, MEM-side handshake/payload,
// forwarding taps and perf counters. master = EX/MEM environment, slave = stage.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_reg_write;
  logic                  in_mem_to_reg;
  logic                  in_mem_write;
  logic [DATA_W-1:0]     in_alu_res;
  logic [DATA_W-1:0]     in_write_data;
  logic [REG_ADDR_W-1:0] in_write_reg;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_reg_write;
  logic                  out_mem_to_reg;
  logic                  out_mem_write;
  logic [DATA_W-1:0]     out_alu_res;
  logic [DATA_W-1:0]     out_write_data;
  logic [REG_ADDR_W-1:0] out_write_reg;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_reg;
  logic [DATA_W-1:0]     fwd_data;
  logic [CNT_W-1:0]      perf_stall_cnt;
  logic [CNT_W-1:0]      perf_bubble_cnt;
  logic [CNT_W-1:0]      perf_flush_cnt;

  modport master (
    output flush, in_valid, in_reg_write, in_mem_to_reg, in_mem_write,
           in_alu_res, in_write_data, in_write_reg, out_ready,
    input  in_ready, out_valid, out_reg_write, out_mem_to_reg, out_mem_write,
           out_alu_res, out_write_data, out_write_reg, fwd_valid, fwd_reg,
           fwd_data, perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt
  );

  modport slave (
    input  flush, in_valid, in_reg_write, in_mem_to_reg, in_mem_write,
           in_alu_res, in_write_data, in_write_reg, out_ready,
    output in_ready, out_valid, out_reg_write, out_mem_to_reg, out_mem_write,
           out_alu_res, out_write_data, out_write_reg, fwd_valid, fwd_reg,
           fwd_data, perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with 2-entry skid buffer, sync flush and forwarding taps.
// Optional perf counters enabled by defining EX_MEM_PERF_CNT_EN.
//
// state   | meaning
// S_EMPTY | no entry held, out_valid=0
// S_ONE   | output register holds an entry
// S_FULL  | output + skid hold entries, in_ready=0
module ex_mem_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset_n,
  ex_mem_pipe_reg_if.slave bus
);
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t r_state, w_next;
  logic   r_in_ready;
  logic   w_accept, w_drain, w_out_valid;
  logic   w_load_out, w_load_skid, w_skid_to_out;

  logic                  r_out_rw, r_out_mtr, r_out_mw;
  logic [DATA_W-1:0]     r_out_alu, r_out_wd;
  logic [REG_ADDR_W-1:0] r_out_reg;
  logic                  r_skid_rw, r_skid_mtr, r_skid_mw;
  logic [DATA_W-1:0]     r_skid_alu, r_skid_wd;
  logic [REG_ADDR_W-1:0] r_skid_reg;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_drain     = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_FULL);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    if (bus.flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) begin
          w_next     = S_ONE;
          w_load_out = 1'b1;
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            w_load_out = 1'b1;
          end else if (w_accept) begin
            w_next      = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_drain) begin
            w_next = S_EMPTY;
          end
        end
        S_FULL: if (w_drain) begin
          w_next        = S_ONE;
          w_skid_to_out = 1'b1;
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_rw   <= 1'b0;
      r_out_mtr  <= 1'b0;
      r_out_mw   <= 1'b0;
      r_out_alu  <= '0;
      r_out_wd   <= '0;
      r_out_reg  <= '0;
      r_skid_rw  <= 1'b0;
      r_skid_mtr <= 1'b0;
      r_skid_mw  <= 1'b0;
      r_skid_alu <= '0;
      r_skid_wd  <= '0;
      r_skid_reg <= '0;
    end else begin
      if (w_load_out) begin
        r_out_rw  <= bus.in_reg_write;
        r_out_mtr <= bus.in_mem_to_reg;
        r_out_mw  <= bus.in_mem_write;
        r_out_alu <= bus.in_alu_res;
        r_out_wd  <= bus.in_write_data;
        r_out_reg <= bus.in_write_reg;
      end else if (w_skid_to_out) begin
        r_out_rw  <= r_skid_rw;
        r_out_mtr <= r_skid_mtr;
        r_out_mw  <= r_skid_mw;
        r_out_alu <= r_skid_alu;
        r_out_wd  <= r_skid_wd;
        r_out_reg <= r_skid_reg;
      end
      if (w_load_skid) begin
        r_skid_rw  <= bus.in_reg_write;
        r_skid_mtr <= bus.in_mem_to_reg;
        r_skid_mw  <= bus.in_mem_write;
        r_skid_alu <= bus.in_alu_res;
        r_skid_wd  <= bus.in_write_data;
        r_skid_reg <= bus.in_write_reg;
      end
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_reg_write  = w_out_valid & r_out_rw;
  assign bus.out_mem_to_reg = w_out_valid & r_out_mtr;
  assign bus.out_mem_write  = w_out_valid & r_out_mw;
  assign bus.out_alu_res    = r_out_alu;
  assign bus.out_write_data = r_out_wd;
  assign bus.out_write_reg  = r_out_reg;
  // Only the output entry is forwarded; EX is stalled while the skid is occupied.
  assign bus.fwd_valid      = w_out_valid & r_out_rw &
                              !((ZERO_REG != 0) && (r_out_reg == '0));
  assign bus.fwd_reg        = r_out_reg;
  assign bus.fwd_data       = r_out_alu;

`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_out_valid && !bus.out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (!w_out_valid && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (bus.flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.perf_stall_cnt  = r_stall_cnt;
  assign bus.perf_bubble_cnt = r_bubble_cnt;
  assign bus.perf_flush_cnt  = r_flush_cnt;
`else
  assign bus.perf_stall_cnt  = {CNT_W{1'b0}};
  assign bus.perf_bubble_cnt = {CNT_W{1'b0}};
  assign bus.perf_flush_cnt  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: table of per-cycle vectors plus hand sequences
// for async reset mid-stream and perf-counter saturation (CNT_W=4).
module tb_ex_mem_pipe_reg;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) bus ();

  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG(1), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic        fl, iv, orr, rw, mw;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        e_ov, e_ir;
    logic [31:0] e_alu;
    logic [4:0]  e_reg;
    logic        e_fv, e_rw, e_mw;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic orr, input logic rw,
                       input logic mw, input logic [31:0] alu, input logic [4:0] wreg);
    bus.flush         = fl;
    bus.in_valid      = iv;
    bus.out_ready     = orr;
    bus.in_reg_write  = rw;
    bus.in_mem_write  = mw;
    bus.in_mem_to_reg = mw;
    bus.in_alu_res    = alu;
    bus.in_write_data = alu + 32'd100;
    bus.in_write_reg  = wreg;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " ov"},  32'(bus.out_valid), 32'd0);
    chk({tag, " ir"},  32'(bus.in_ready), 32'd1);
    chk({tag, " alu"}, bus.out_alu_res, 32'd0);
    chk({tag, " wd"},  bus.out_write_data, 32'd0);
    chk({tag, " reg"}, 32'(bus.out_write_reg), 32'd0);
    chk({tag, " ctl"}, 32'({bus.out_reg_write, bus.out_mem_write, bus.out_mem_to_reg}), 32'd0);
    chk({tag, " fwd"}, 32'({bus.fwd_valid, bus.fwd_reg}), 32'd0);
    chk({tag, " fdat"}, bus.fwd_data, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++)
      vecs[k] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'(k + 1), 5'(k + 1),
                  1'b1, 1'b1, 32'(k + 1), 5'(k + 1), 1'b1, 1'b1, 1'b0};
    //           fl    iv    orr   rw    mw    alu       reg     ov    ir    e_alu     e_reg   fv    rw    mw
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b1, 32'h8,    5'd8, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA,    5'd0, 1'b1, 1'b1, 32'hA,    5'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hB,    5'd5, 1'b1, 1'b0, 32'hA,    5'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hEE,   5'd9, 1'b1, 1'b0, 32'hA,    5'd0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    5'd0, 1'b1, 1'b1, 32'hB,    5'd5, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b1, 32'hB,    5'd5, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1,    5'd3, 1'b1, 1'b1, 32'h1,    5'd3, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2,    5'd4, 1'b1, 1'b0, 32'h1,    5'd3, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC,    5'd6, 1'b0, 1'b1, 32'h1,    5'd3, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b1, 32'h1,    5'd3, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hD,    5'd2, 1'b0, 1'b1, 32'h1,    5'd3, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h30,   5'd7, 1'b1, 1'b1, 32'h30,   5'd7, 1'b1, 1'b1, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    reset_n = 1'b0;
    #12;
    chk_zero_outputs("reset");
    chk("reset perf", 32'({bus.perf_stall_cnt, bus.perf_bubble_cnt, bus.perf_flush_cnt}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].orr, vecs[i].rw, vecs[i].mw, vecs[i].alu, vecs[i].wreg);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ov", i),  32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d ir", i),  32'(bus.in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d alu", i), bus.out_alu_res, vecs[i].e_alu);
      chk($sformatf("v%0d wd", i),  bus.out_write_data, vecs[i].e_alu + 32'd100);
      chk($sformatf("v%0d reg", i), 32'(bus.out_write_reg), 32'(vecs[i].e_reg));
      chk($sformatf("v%0d rw", i),  32'(bus.out_reg_write), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d mw", i),  32'(bus.out_mem_write), 32'(vecs[i].e_mw));
      chk($sformatf("v%0d mtr", i), 32'(bus.out_mem_to_reg), 32'(vecs[i].e_mw));
      chk($sformatf("v%0d fv", i),  32'(bus.fwd_valid), 32'(vecs[i].e_fv));
      chk($sformatf("v%0d freg", i), 32'(bus.fwd_reg), 32'(vecs[i].e_reg));
      chk($sformatf("v%0d fdat", i), bus.fwd_data, vecs[i].e_alu);
    end

    // Async reset in the middle of a stream: outputs clear before the next edge.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 5'd9);
    @(posedge clk);
    #1;
    chk("pre-reset ov", 32'(bus.out_valid), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("async reset");

    // Perf: one bubble edge, 20 stall edges, then a flush edge.
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h77, 5'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("stall ov", 32'(bus.out_valid), 32'd1);
    chk("stall alu", bus.out_alu_res, 32'h77);
`ifdef EX_MEM_PERF_CNT_EN
    chk("perf stall sat", 32'(bus.perf_stall_cnt), 32'd15);
`else
    chk("perf stall off", 32'(bus.perf_stall_cnt), 32'd0);
`endif
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    @(posedge clk);
    #1;
    chk("flush ov", 32'(bus.out_valid), 32'd0);
    chk("flush ir", 32'(bus.in_ready), 32'd1);
`ifdef EX_MEM_PERF_CNT_EN
    chk("perf stall", 32'(bus.perf_stall_cnt), 32'd15);
    chk("perf bubble", 32'(bus.perf_bubble_cnt), 32'd1);
    chk("perf flush", 32'(bus.perf_flush_cnt), 32'd1);
`else
    chk("perf stall off2", 32'(bus.perf_stall_cnt), 32'd0);
    chk("perf bubble off", 32'(bus.perf_bubble_cnt), 32'd0);
    chk("perf flush off", 32'(bus.perf_flush_cnt), 32'd0);
`endif
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
